// File: rtl/m_src_arb_if.sv
// ---------------------------------------------------------------------------
// m_src_arb_if
// Bundles the M-bus source arbiter's decode/state inputs, per-source
// requests and the drive/grant/diagnostic outputs.
//   master : source-select decode side (drives state_*, src_req, conflict_clr)
//   slave  : arbiter side (drives drive, grant, conflict, conflict_cnt)
// Parameters NSRC and CNTW must match the attached m_src_arb instance.
// ---------------------------------------------------------------------------
interface m_src_arb_if #(
    parameter int NSRC = 4,
    parameter int CNTW = 8
);
    logic            state_decode;
    logic            state_alu;
    logic            state_write;
    logic            state_mmu;
    logic            state_fetch;
    logic [NSRC-1:0] src_req;
    logic            conflict_clr;
    logic [NSRC-1:0] drive;
    logic [NSRC-1:0] grant;
    logic            conflict;
    logic [CNTW-1:0] conflict_cnt;

    modport master (
        output state_decode, state_alu, state_write, state_mmu, state_fetch,
        output src_req, conflict_clr,
        input  drive, grant, conflict, conflict_cnt
    );

    modport slave (
        input  state_decode, state_alu, state_write, state_mmu, state_fetch,
        input  src_req, conflict_clr,
        output drive, grant, conflict, conflict_cnt
    );
endinterface

// File: rtl/m_src_arb.sv
// ---------------------------------------------------------------------------
// m_src_arb
// M-bus source arbiter. On every state_decode cycle it samples src_req and
// latches a one-hot grant (default source DFLT when nobody requests). The
// granted source's drive line is asserted while any of the ALU / WRITE / MMU /
// FETCH states is active. Decodes with more than one request are recorded in
// a sticky flag and a saturating counter.
// Ports:
//   clk    : system clock, all state updates on its rising edge
//   reset  : synchronous, active-high reset
//   bus    : m_src_arb_if.slave (state_*, src_req, conflict_clr in;
//            drive, grant, conflict, conflict_cnt out)
// Parameters: NSRC sources, DFLT default index, MODE 0=fixed priority /
//   1=round-robin, PIPE 0=combinational drive / 1=registered drive,
//   CNTW conflict counter width.
// ---------------------------------------------------------------------------
module m_src_arb #(
    parameter int NSRC = 4,
    parameter int DFLT = 0,
    parameter int MODE = 0,
    parameter int PIPE = 0,
    parameter int CNTW = 8
) (
    input  logic       clk,
    input  logic       reset,
    m_src_arb_if.slave bus
);
    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC-1:0] r_grant;
    logic [PW-1:0]   r_ptr;
    logic            r_conflict;
    logic [CNTW-1:0] r_conflict_cnt;

    logic            w_active;
    logic            w_any;
    logic            w_multi;
    logic            w_found;
    logic [PW-1:0]   w_idx;
    logic [PW-1:0]   w_win_idx;
    logic [NSRC-1:0] w_pick;
    logic [NSRC-1:0] w_drive_now;

    assign w_active = bus.state_alu | bus.state_write | bus.state_mmu | bus.state_fetch;
    assign w_any    = |bus.src_req;
    assign w_multi  = ($countones(bus.src_req) > 1);

    // Winner selection. Round-robin searches upward starting one past the
    // last winner, so the most recent winner has the lowest priority.
    always_comb begin
        w_win_idx = '0;
        w_idx     = '0;
        w_found   = 1'b0;
        w_pick    = '0;
        if (MODE == 0) begin
            for (int i = NSRC - 1; i >= 0; i--) begin
                if (bus.src_req[i]) begin
                    w_win_idx = PW'(i);
                end
            end
        end else begin
            for (int k = 1; k <= NSRC; k++) begin
                w_idx = PW'((int'(r_ptr) + k) % NSRC);
                if (!w_found && bus.src_req[w_idx]) begin
                    w_found   = 1'b1;
                    w_win_idx = w_idx;
                end
            end
        end
        if (w_any) begin
            w_pick = NSRC'(1) << w_win_idx;
        end else begin
            w_pick = NSRC'(1) << DFLT;
        end
    end

    // Grant latch and round-robin pointer. A default grant leaves the
    // pointer alone so an idle decode does not disturb fairness.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant <= '0;
            r_ptr   <= PW'(NSRC - 1);
        end else if (bus.state_decode) begin
            r_grant <= w_pick;
            if (w_any) begin
                r_ptr <= w_win_idx;
            end
        end
    end

    // Conflict diagnostics. A conflicting decode in the same cycle as a clear
    // counts as the first event after the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_conflict     <= 1'b0;
            r_conflict_cnt <= '0;
        end else if (bus.state_decode && w_multi) begin
            r_conflict <= 1'b1;
            if (bus.conflict_clr) begin
                r_conflict_cnt <= CNTW'(1);
            end else if (r_conflict_cnt != {CNTW{1'b1}}) begin
                r_conflict_cnt <= r_conflict_cnt + CNTW'(1);
            end
        end else if (bus.conflict_clr) begin
            r_conflict     <= 1'b0;
            r_conflict_cnt <= '0;
        end
    end

    // Drive always uses the grant held before the current edge, so a decode
    // coinciding with an active state still drives the previous winner.
    assign w_drive_now = r_grant & {NSRC{w_active}};

    generate
        if (PIPE != 0) begin : g_pipe
            logic [NSRC-1:0] r_drive;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_drive <= '0;
                end else begin
                    r_drive <= w_drive_now;
                end
            end
            assign bus.drive = r_drive;
        end else begin : g_comb
            assign bus.drive = w_drive_now;
        end
    endgenerate

    assign bus.grant        = r_grant;
    assign bus.conflict     = r_conflict;
    assign bus.conflict_cnt = r_conflict_cnt;
endmodule
